sram_sched: RTL
===============

# sram_sched

Sequencing controller and two-master arbiter for the board's asynchronous 16-bit SRAM. It accepts Avalon-MM transfers from the SOPC system (`sopc_*`) and the test runner (`tr_*`), and grants them round-robin. It runs each granted transfer as a timed SRAM cycle with registered strobes, then completes it with a one-cycle waitrequest release. The block sits between both masters and the SRAM pins and replaces software-driven master selection.

## Interface
- `ADDR_WIDTH`, 20: SRAM word address width.
- `DATA_WIDTH`, 16: data width.
- `BE_WIDTH`, `DATA_WIDTH/8`: byte-enable width.
- `WAIT_CYCLES`, 2: strobe-active cycles per access; legal range 1..15.
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sopc_address`, `tr_address`  in  ADDR_WIDTH  word address.
- `sopc_byteenable`, `tr_byteenable`  in  BE_WIDTH  active-high byte enables.
- `sopc_read`, `tr_read`  in  1  read request.
- `sopc_write`, `tr_write`  in  1  write request.
- `sopc_writedata`, `tr_writedata`  in  DATA_WIDTH  write data.
- `sopc_readdata`, `tr_readdata`  out  DATA_WIDTH  registered read data; both ports carry the same register.
- `sopc_waitrequest`, `tr_waitrequest`  out  1  Avalon waitrequest.
- `sram_address`  out  ADDR_WIDTH  registered address.
- `sram_data`  inout  DATA_WIDTH  SRAM data bus.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1  active-low SRAM strobes.
- `sram_be_n`  out  BE_WIDTH  active-low byte selects.
- `grant`  out  1  current/last owner; 0 = sopc, 1 = tr.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE → ACCESS → ACK → IDLE.
- **IDLE**
  - A master requests when its `read | write` is high.
  - One requester: that requester is granted.
  - Both request: the master other than `grant` wins.
  - On grant, latch address, byteenable, writedata and direction; set counter = WAIT_CYCLES-1; go to ACCESS.
- **ACCESS**
  - `sram_ce_n` = 0 and `sram_be_n` = ~byteenable.
  - Read: `sram_oe_n` = 0 and the bus is tri-stated.
  - Write: `sram_we_n` = 0 and the bus is driven with the latched data.
  - Counter decrements each cycle. At counter = 0, a read captures `sram_data` into the readdata register, then the FSM goes to ACK.
- **ACK**
  - All strobes high; the write bus stays driven one more cycle for hold time.
  - The granted master's waitrequest is 0 for this single cycle; the FSM then returns to IDLE.
- Waitrequest = ~(state == ACK && grant == port); it is high in every other cycle, including idle.
- Read and write asserted together: treated as a read; the write is ignored.
- Request inputs changing mid-transfer: ignored. The latched copy completes, and the master is acked regardless.
- Readdata is overwritten only by reads. Writes leave it unchanged.

## Timing
- Reset values: `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1; `sram_be_n` = all 1; `sram_address` = 0; `sram_data` = Z; readdata = 0; both waitrequests = 1; `grant` = 1 (so sopc wins the first tie); `busy` = 0; FSM = IDLE.
- Request sampled in IDLE at cycle 0:
  - ACCESS in cycles 1..WAIT_CYCLES.
  - ACK (waitrequest low) in cycle WAIT_CYCLES+1.
  - Readdata is valid in the ACK cycle.
- Throughput: one transfer every WAIT_CYCLES+2 cycles. A pending request is sampled in the IDLE cycle that follows ACK.
- Back-to-back with both masters requesting: strict alternation.
- Reset asserted mid-transfer: the asynchronous reset forces all strobes inactive and the bus to Z immediately. The in-flight transfer is dropped and never acked.
- All SRAM outputs are driven from registers; no combinational path from master inputs to pins.

## Structure
- Package `sram_sched_pkg` holds:
  - state enum (IDLE, ACCESS, ACK);
  - constants `MASTER_SOPC` = 0 and `MASTER_TR` = 1;
  - counter width constant (4 bits).
- Sub-module `sram_rr_arb`: a 2-way round-robin grant picker.
  - Combinational pick from the request pair and the last-grant register.
  - The last-grant register updates only on an IDLE→ACCESS transition.

## Test plan
- Reset, then idle 10 cycles → all strobes 1, bus Z, both waitrequests 1, `busy` 0.
- WAIT_CYCLES = 2. sopc writes 0xBEEF to 0x00010 with be = 2'b11 → `sram_we_n` low in cycles 1–2, bus 0xBEEF in cycles 1–3, `sopc_waitrequest` low only in cycle 3.
- tr reads 0x00010 with an SRAM model → `tr_readdata` = 0xBEEF in the ACK cycle (cycle 3); `sram_oe_n` low in cycles 1–2.
- Both masters request continuously from reset → grants sopc, tr, sopc, tr; each waitrequest drops once per 8 cycles.
- sopc asserts read and write together at 0x00020 → `sram_oe_n` toggles, `sram_we_n` stays 1.
- Reset pulsed in cycle 2 of a write → `sram_we_n` goes to 1 asynchronously, no ack is issued, and the next request proceeds normally.

Source files
------------

// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the SRAM sequencer and its arbiter.
package sram_sched_pkg;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_e;

   // Master identifiers as carried on the grant output
   localparam logic MASTER_SOPC = 1'b0;
   localparam logic MASTER_TR   = 1'b1;

   // Width of the strobe-active cycle counter (WAIT_CYCLES up to 15)
   localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin grant picker. The pick is combinational; the
// last-grant register only moves when a transfer is actually launched.
module sram_rr_arb
   import sram_sched_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req_i,     // bit 0 = sopc, bit 1 = tr
   input  logic       update_i,  // high on the IDLE->ACCESS transition
   output logic       pick_o,
   output logic       last_o
);

   logic last_q;

   // Choose a winner: a lone requester wins, a tie goes to the non-last master
   always_comb begin
      pick_o = MASTER_SOPC;
      if (req_i == 2'b11) begin
         pick_o = ~last_q;
      end else if (req_i[1]) begin
         pick_o = MASTER_TR;
      end
   end

   // Remember who was granted; resets to tr so sopc wins the first tie
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_q <= MASTER_TR;
      end else if (update_i) begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         last_q <= pick_o;
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/sram_sched.sv
// Two-master Avalon-MM front end for an asynchronous SRAM. Grants transfers
// round-robin, runs a timed strobe window with registered pins, and releases
// waitrequest for exactly one cycle to complete each transfer.
module sram_sched
   import sram_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int BE_WIDTH    = DATA_WIDTH / 8,
   parameter int WAIT_CYCLES = 2
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] sopc_address,
   input  logic [BE_WIDTH-1:0]   sopc_byteenable,
   input  logic                  sopc_read,
   input  logic                  sopc_write,
   input  logic [DATA_WIDTH-1:0] sopc_writedata,
   output logic [DATA_WIDTH-1:0] sopc_readdata,
   output logic                  sopc_waitrequest,
   input  logic [ADDR_WIDTH-1:0] tr_address,
   input  logic [BE_WIDTH-1:0]   tr_byteenable,
   input  logic                  tr_read,
   input  logic                  tr_write,
   input  logic [DATA_WIDTH-1:0] tr_writedata,
   output logic [DATA_WIDTH-1:0] tr_readdata,
   output logic                  tr_waitrequest,
   output logic [ADDR_WIDTH-1:0] sram_address,
   inout  wire  [DATA_WIDTH-1:0] sram_data,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic [BE_WIDTH-1:0]   sram_be_n,
   output logic                  grant,
   output logic                  busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

   state_e                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BE_WIDTH-1:0]     be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    rd_q, rd_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    ce_n_q, ce_n_d;
   logic                    oe_n_q, oe_n_d;
   logic                    we_n_q, we_n_d;
   logic [BE_WIDTH-1:0]     be_n_q, be_n_d;
   logic                    drive_q, drive_d;

   logic [1:0] req;
   logic       launch;
   logic       pick;

   assign req    = {tr_read | tr_write, sopc_read | sopc_write};
   assign launch = (state_q == ST_IDLE) && (req != 2'b00);

   sram_rr_arb u_arb (
      .clock    (clock),
      .reset    (reset),
      .req_i    (req),
      .update_i (launch),
      .pick_o   (pick),
      .last_o   (grant)
   );

   // Next-state, transfer latching and registered-pin values
   always_comb begin
      // NOTE: every target gets a default first so no path through the block infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      rdata_d = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               state_d = ST_ACCESS;
               cnt_d   = CNT_RELOAD;
               if (pick == MASTER_TR) begin
                  addr_d  = tr_address;
                  be_d    = tr_byteenable;
                  wdata_d = tr_writedata;
                  rd_d    = tr_read;     // read wins when both are asserted
               end else begin
                  addr_d  = sopc_address;
                  be_d    = sopc_byteenable;
                  wdata_d = sopc_writedata;
                  rd_d    = sopc_read;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
               if (rd_q) begin
                  rdata_d = sram_data;
               end
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pins are computed from the next state so they register in step with it
      ce_n_d  = (state_d != ST_ACCESS);
      oe_n_d  = !((state_d == ST_ACCESS) && rd_d);
      we_n_d  = !((state_d == ST_ACCESS) && !rd_d);
      be_n_d  = (state_d == ST_ACCESS) ? ~be_d : '1;
      drive_d = (state_d != ST_IDLE) && !rd_d;   // includes ACK for write hold
   end

   // State and datapath registers; reset drops any in-flight transfer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: datapath registers are reset too; they are few and the pins must come up defined.
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         be_n_q  <= '1;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         rdata_q <= rdata_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         be_n_q  <= be_n_d;
         drive_q <= drive_d;
      end
   end

   assign sram_address     = addr_q;
   assign sram_ce_n        = ce_n_q;
   assign sram_oe_n        = oe_n_q;
   assign sram_we_n        = we_n_q;
   assign sram_be_n        = be_n_q;
   assign sram_data        = drive_q ? wdata_q : 'z;

   assign sopc_readdata    = rdata_q;
   assign tr_readdata      = rdata_q;
   assign sopc_waitrequest = !((state_q == ST_ACK) && (grant == MASTER_SOPC));
   assign tr_waitrequest   = !((state_q == ST_ACK) && (grant == MASTER_TR));
   assign busy             = (state_q != ST_IDLE);

endmodule
